// File: rtl/tape_mode_select_pkg.sv
// Shared mode-id constants, mode counts and debouncer state encoding for the
// tape load/save mode selector.
package tape_mode_select_pkg;

    localparam logic [1:0] LOAD_NORMAL_WAV = 2'd0;
    localparam logic [1:0] LOAD_TURBO_TAP  = 2'd1;

    localparam logic [1:0] SAVE_NORMAL_WAV = 2'd0;
    localparam logic [1:0] SAVE_TURBO_TAP  = 2'd1;
    localparam logic [1:0] SAVE_NORMAL_TAP = 2'd2;

    localparam int unsigned LOAD_MODES = 2;
    localparam int unsigned SAVE_MODES = 3;

    typedef enum logic [1:0] {
        StIdle        = 2'd0,
        StPressWait   = 2'd1,
        StHeld        = 2'd2,
        StReleaseWait = 2'd3
    } debounce_state_t;

    // Advance a mode id, wrapping to 0 after the last mode; out-of-range ids also wrap to 0.
    function automatic logic [1:0] next_mode(input logic [1:0] cur, input int unsigned modes);
        if ({30'd0, cur} + 32'd1 >= modes) begin
            return 2'd0;
        end
        return cur + 2'd1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus press/release debounce FSM for one active-low button.
// Optional auto-repeat while held is enabled by defining TAPE_MODE_AUTOREPEAT_EN.
module button_debounce
    import tape_mode_select_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 568400,
    parameter int unsigned REPEAT_CYCLES   = 28420000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_btn_n,
    output logic o_strobe
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("button_debounce: DEBOUNCE_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
    end

    logic [1:0]       sync_q;
    logic             btn_low;
    debounce_state_t  state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;

`ifdef TAPE_MODE_AUTOREPEAT_EN
    localparam int unsigned RPT_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
    logic [RPT_W-1:0] rpt_q;
`endif

    // Reset to the released (high) level so a held button needs a full debounce afterwards.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_btn_n};
        end
    end

    assign btn_low = ~sync_q[1];
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            o_strobe <= 1'b0;
`ifdef TAPE_MODE_AUTOREPEAT_EN
            rpt_q    <= '0;
`endif
        end else begin
            o_strobe <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (btn_low) begin
                        state_q <= StPressWait;
                        cnt_q   <= CNT_ONE;
                    end
                end
                StPressWait: begin
                    if (!btn_low) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (cnt_q >= CNT_LAST) begin
                        state_q  <= StHeld;
                        cnt_q    <= '0;
                        o_strobe <= 1'b1;
`ifdef TAPE_MODE_AUTOREPEAT_EN
                        rpt_q    <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StHeld: begin
                    if (!btn_low) begin
                        state_q <= StReleaseWait;
                        cnt_q   <= CNT_ONE;
`ifdef TAPE_MODE_AUTOREPEAT_EN
                    end else if (rpt_q >= RPT_LAST) begin
                        o_strobe <= 1'b1;
                        rpt_q    <= '0;
                    end else begin
                        rpt_q <= rpt_q + RPT_ONE;
`endif
                    end
                end
                StReleaseWait: begin
                    // A low sample here is release bounce: back to held without a strobe.
                    if (btn_low) begin
                        state_q <= StHeld;
                        cnt_q   <= '0;
`ifdef TAPE_MODE_AUTOREPEAT_EN
                        rpt_q   <= '0;
`endif
                    end else if (cnt_q >= CNT_LAST) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/tape_mode_select.sv
// Tape load/save mode selector: two debounced buttons cycle the mode ids.
// Define TAPE_MODE_AUTOREPEAT_EN to auto-repeat a held button.
module tape_mode_select
    import tape_mode_select_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 568400,
    parameter int unsigned REPEAT_CYCLES   = 28420000
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_btn_load_n,
    input  logic       i_btn_save_n,
    input  logic       i_tape_busy,
    output logic [1:0] o_load_mode_id,
    output logic [1:0] o_save_mode_id,
    output logic       o_mode_changed
);

    logic load_strobe;
    logic save_strobe;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_load_debounce (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_btn_n  (i_btn_load_n),
        .o_strobe (load_strobe)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_save_debounce (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_btn_n  (i_btn_save_n),
        .o_strobe (save_strobe)
    );

    // Strobes seen while the tape is busy are dropped, not deferred.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_load_mode_id <= LOAD_NORMAL_WAV;
            o_save_mode_id <= SAVE_NORMAL_WAV;
            o_mode_changed <= 1'b0;
        end else begin
            o_mode_changed <= 1'b0;
            if (!i_tape_busy) begin
                if (load_strobe) begin
                    o_load_mode_id <= next_mode(o_load_mode_id, LOAD_MODES);
                end
                if (save_strobe) begin
                    o_save_mode_id <= next_mode(o_save_mode_id, SAVE_MODES);
                end
                o_mode_changed <= load_strobe | save_strobe;
            end
        end
    end

endmodule

// File: tb/tb_tape_mode_select.sv
// Self-checking bench for tape_mode_select: directed and randomized button presses
// checked against a press-counting model of the mode ids and change pulses.
module tb_tape_mode_select;

    localparam int unsigned DEB = 8;
    localparam int unsigned RPT = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_n;
    logic       save_n;
    logic       busy;
    logic [1:0] load_id;
    logic [1:0] save_id;
    logic       changed;

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;
    int acc_load    = 0;
    int acc_save    = 0;
    int exp_pulses  = 0;

    always #5 clk = ~clk;

    tape_mode_select #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_CYCLES   (RPT)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_btn_load_n   (load_n),
        .i_btn_save_n   (save_n),
        .i_tape_busy    (busy),
        .o_load_mode_id (load_id),
        .o_save_mode_id (save_id),
        .o_mode_changed (changed)
    );

    always @(negedge clk) begin
        if (changed === 1'b1) pulses++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model: each accepted press advances its mode modulo the mode count.
    task automatic check_model(input string tag);
        check({tag, ".load"}, {30'd0, load_id}, acc_load % 2);
        check({tag, ".save"}, {30'd0, save_id}, acc_save % 3);
        check({tag, ".pulses"}, pulses, exp_pulses);
    endtask

    task automatic drive(input bit do_load, input bit do_save, input logic lvl);
        if (do_load) load_n = lvl;
        if (do_save) save_n = lvl;
    endtask

    task automatic press(input bit do_load, input bit do_save, input int hold,
                         input int nbounce, input bit rel_bounce, input bit busy_now);
        busy = busy_now;
        for (int b = 0; b < nbounce; b++) begin
            drive(do_load, do_save, 1'b0);
            cyc($urandom_range(1, DEB - 2));
            drive(do_load, do_save, 1'b1);
            cyc($urandom_range(1, 4));
        end
        drive(do_load, do_save, 1'b0);
        cyc(hold);
        drive(do_load, do_save, 1'b1);
        if (rel_bounce) begin
            cyc($urandom_range(1, 4));
            drive(do_load, do_save, 1'b0);
            cyc($urandom_range(1, DEB - 2));
            drive(do_load, do_save, 1'b1);
        end
        cyc(DEB + 6);
        busy = 1'b0;
        cyc(1);
        if (!busy_now) begin
            if (do_load) acc_load++;
            if (do_save) acc_save++;
            exp_pulses++;
        end
    endtask

    initial begin
        rst    = 1'b1;
        load_n = 1'b1;
        save_n = 1'b1;
        busy   = 1'b0;
        cyc(3);
        check("reset.load", {30'd0, load_id}, 0);
        check("reset.save", {30'd0, save_id}, 0);
        check("reset.changed", {31'd0, changed}, 0);
        rst = 1'b0;
        cyc(3);

        // Clean save press held 20 cycles: pulse exactly DEB+3 cycles after the fall.
        save_n = 1'b0;
        cyc(DEB + 2);
        check("clean.early", {31'd0, changed}, 0);
        cyc(1);
        check("clean.pulse", {31'd0, changed}, 1);
        check("clean.save", {30'd0, save_id}, 1);
        cyc(1);
        check("clean.after", {31'd0, changed}, 0);
        cyc(20 - DEB - 4);
        save_n = 1'b1;
        cyc(DEB + 6);
        acc_save++;
        exp_pulses++;
        check_model("clean");

        // Load bouncing every 3 cycles never qualifies.
        for (int i = 0; i < 10; i++) begin
            load_n = ~load_n;
            cyc(3);
        end
        load_n = 1'b1;
        cyc(DEB + 6);
        check_model("bouncy");

        // Sequences from reset: save 1,2,0,1 and load 1,0.
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        acc_load = 0;
        acc_save = 0;
        cyc(2);
        for (int i = 0; i < 4; i++) begin
            press(1'b0, 1'b1, DEB + 6, 0, 1'b0, 1'b0);
            check_model("seq_save");
        end
        for (int i = 0; i < 2; i++) begin
            press(1'b1, 1'b0, DEB + 6, 0, 1'b0, 1'b0);
            check_model("seq_load");
        end

        // Simultaneous strobes, then the same presses while busy.
        press(1'b1, 1'b1, DEB + 6, 0, 1'b0, 1'b0);
        check_model("both");
        press(1'b1, 1'b1, DEB + 6, 0, 1'b0, 1'b1);
        check_model("both_busy");

        // Randomized presses with bounce, release bounce and busy.
        for (int i = 0; i < 12; i++) begin
            int sel;
            sel = int'($urandom_range(0, 2));
            press(sel != 1, sel != 0, int'($urandom_range(DEB + 2, DEB + 20)),
                  int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                  $urandom_range(0, 3) == 0);
            check_model("rand");
        end

`ifdef TAPE_MODE_AUTOREPEAT_EN
        // Held 100 cycles: initial strobe plus two repeats.
        save_n = 1'b0;
        cyc(100);
        save_n = 1'b1;
        cyc(DEB + 6);
        acc_save += 3;
        exp_pulses += 3;
        check_model("repeat");
`else
        // Long hold yields a single strobe.
        press(1'b1, 1'b0, 200, 0, 1'b0, 1'b0);
        check_model("long_hold");
`endif

        // Reset at cycle 5 of a press, button released with reset: no strobe.
        save_n = 1'b0;
        cyc(5);
        rst = 1'b1;
        cyc(1);
        check("rst_mid.load", {30'd0, load_id}, 0);
        check("rst_mid.save", {30'd0, save_id}, 0);
        check("rst_mid.changed", {31'd0, changed}, 0);
        save_n = 1'b1;
        cyc(1);
        rst = 1'b0;
        acc_load = 0;
        acc_save = 0;
        cyc(DEB + 8);
        check_model("rst_mid");

        // Button still held across reset release needs a full debounce.
        save_n = 1'b0;
        cyc(5);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(DEB + 2);
        check("rst_held.early", {31'd0, changed}, 0);
        cyc(1);
        check("rst_held.pulse", {31'd0, changed}, 1);
        save_n = 1'b1;
        cyc(DEB + 6);
        acc_save++;
        exp_pulses++;
        check_model("rst_held");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
